// File: rtl/wb_lsq_retire_pkg.sv
// Shared RV32/RV64 load-path types: load funct3 encoding and retire-buffer entry.
package rv32imc_types;

  localparam int XLEN_MAX = 64;
  localparam int OFF_MAX  = 3;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LD  = 3'd3,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5,
    F3_LWU = 3'd6
  } load_funct3_e;

  // Entry is sized for the widest datapath; narrower builds use the low bits.
  typedef struct packed {
    logic                is_load;
    load_funct3_e        funct3;
    logic [OFF_MAX-1:0]  off;
    logic [4:0]          rd;
    logic                done;
    logic [XLEN_MAX-1:0] data;
  } wb_lsq_entry_t;

endpackage

// File: rtl/wb_lsq_retire_align.sv
// Load data alignment: selects byte/half/word at the access offset and extends to XLEN.
module wb_load_align
  import rv32imc_types::*;
#(
  parameter  int XLEN = 32,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] data,
  input  load_funct3_e    funct3,
  input  logic [OFFW-1:0] off,
  output logic [XLEN-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  // Halfword ignores off[0]; word on RV64 is picked by off[2], RV32 word is the whole bus.
  assign b = 8'(data >> {off, 3'b000});
  assign h = 16'(data >> {off[OFFW-1:1], 4'b0000});
  assign w = (XLEN == 32) ? data[31:0] : 32'(data >> {off[OFFW-1], 5'b00000});

  // Extension per load type; encodings illegal for this XLEN give zero.
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = XLEN'($signed(b));
      F3_LBU:  result = XLEN'(b);
      F3_LH:   result = XLEN'($signed(h));
      F3_LHU:  result = XLEN'(h);
      F3_LW:   result = XLEN'($signed(w));
      F3_LWU:  result = (XLEN == 64) ? XLEN'(w) : '0;
      F3_LD:   result = (XLEN == 64) ? data : '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/wb_lsq_retire.sv
// In-order retire buffer between memory stage and writeback; captures responses during stalls.
module wb_lsq_retire
  import rv32imc_types::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int OFFW  = $clog2(XLEN/8),
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_is_load,
  input  logic [2:0]      issue_funct3,
  input  logic [OFFW-1:0] issue_off,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            wb_advance,
  output logic            head_valid,
  output logic            head_done,
  output logic            o_regf_we,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_write_data,
  output logic [CW-1:0]   count,
  output logic            resp_err
);

  wb_lsq_entry_t   mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]   head, tail, rptr;
  logic [CW-1:0]   cnt;

  wb_lsq_entry_t   hd, rq;
  logic            resp_hit, bypass, retire, push;
  logic [XLEN-1:0] src, aligned;
  logic            unused_ok;

  assign hd = mem[head];
  assign rq = mem[rptr];

  // rptr always sits on the oldest not-done entry, or on a slot that is empty/done.
  assign resp_hit    = dmem_resp & vld[rptr] & ~rq.done;
  assign bypass      = resp_hit & (rptr == head);
  assign head_valid  = vld[head];
  assign head_done   = head_valid & (hd.done | bypass);
  assign retire      = wb_advance & head_done;
  assign issue_ready = (cnt < CW'(DEPTH)) | retire;
  assign push        = issue_valid & issue_ready;
  assign count       = cnt;

  assign src = bypass ? dmem_rdata : hd.data[XLEN-1:0];

  wb_load_align #(.XLEN(XLEN)) u_align (
    .data   (src),
    .funct3 (hd.funct3),
    .off    (hd.off[OFFW-1:0]),
    .result (aligned)
  );

  assign o_regf_we    = head_done & hd.is_load & (hd.rd != 5'd0);
  assign o_rd_addr    = head_valid ? hd.rd : 5'd0;
  assign o_write_data = (head_done & hd.is_load) ? aligned : '0;

  // Entry fields wider than this XLEN, and the rptr entry payload, are not consumed.
  assign unused_ok = ^{hd.data, hd.off, rq};

  // Buffer state: response capture, then retire, then push so a reused slot ends up fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      vld      <= '0;
      resp_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i].done <= 1'b0;
    end else begin
      resp_err <= resp_err | (dmem_resp & ~resp_hit);
      cnt      <= cnt + CW'(push) - CW'(retire);
      if (resp_hit) begin
        mem[rptr].done <= 1'b1;
        mem[rptr].data <= XLEN_MAX'(dmem_rdata);
        rptr           <= rptr + PW'(1);
      end
      if (retire) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      if (push) begin
        mem[tail] <= '{is_load: issue_is_load,
                       funct3:  load_funct3_e'(issue_funct3),
                       off:     OFF_MAX'(issue_off),
                       rd:      issue_rd,
                       done:    1'b0,
                       data:    '0};
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_lsq_retire.sv
// Scoreboard bench: expected retirements queued at issue, checked by a negedge monitor.
module tb_wb_lsq_retire;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_issue_valid, a_issue_is_load, a_issue_ready;
  logic [2:0]  a_issue_funct3;
  logic [1:0]  a_issue_off;
  logic [4:0]  a_issue_rd, a_rd_addr;
  logic        a_dmem_resp, a_wb_advance, a_head_valid, a_head_done, a_regf_we, a_resp_err;
  logic [31:0] a_dmem_rdata, a_wdata;
  logic [2:0]  a_count;

  // 64-bit instance
  logic        b_issue_valid, b_issue_is_load, b_issue_ready;
  logic [2:0]  b_issue_funct3;
  logic [2:0]  b_issue_off;
  logic [4:0]  b_issue_rd, b_rd_addr;
  logic        b_dmem_resp, b_wb_advance, b_head_valid, b_head_done, b_regf_we, b_resp_err;
  logic [63:0] b_dmem_rdata, b_wdata;
  logic [2:0]  b_count;

  wb_lsq_retire #(.XLEN(32), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .issue_valid(a_issue_valid), .issue_is_load(a_issue_is_load),
    .issue_funct3(a_issue_funct3), .issue_off(a_issue_off), .issue_rd(a_issue_rd),
    .issue_ready(a_issue_ready), .dmem_resp(a_dmem_resp), .dmem_rdata(a_dmem_rdata),
    .wb_advance(a_wb_advance), .head_valid(a_head_valid), .head_done(a_head_done),
    .o_regf_we(a_regf_we), .o_rd_addr(a_rd_addr), .o_write_data(a_wdata),
    .count(a_count), .resp_err(a_resp_err)
  );

  wb_lsq_retire #(.XLEN(64), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .issue_valid(b_issue_valid), .issue_is_load(b_issue_is_load),
    .issue_funct3(b_issue_funct3), .issue_off(b_issue_off), .issue_rd(b_issue_rd),
    .issue_ready(b_issue_ready), .dmem_resp(b_dmem_resp), .dmem_rdata(b_dmem_rdata),
    .wb_advance(b_wb_advance), .head_valid(b_head_valid), .head_done(b_head_done),
    .o_regf_we(b_regf_we), .o_rd_addr(b_rd_addr), .o_write_data(b_wdata),
    .count(b_count), .resp_err(b_resp_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every retirement pops the oldest expectation for that instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_wb_advance && a_head_done) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_retire: got rd %0d want none", a_rd_addr);
        end else begin
          ea = qa.pop_front();
          chk("a_rd", 64'(a_rd_addr), 64'(ea.rd));
          chk("a_we", 64'(a_regf_we), 64'(ea.we));
          chk("a_data", 64'(a_wdata), ea.data);
        end
      end
      if (b_wb_advance && b_head_done) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_retire: got rd %0d want none", b_rd_addr);
        end else begin
          eb = qb.pop_front();
          chk("b_rd", 64'(b_rd_addr), 64'(eb.rd));
          chk("b_we", 64'(b_regf_we), 64'(eb.we));
          chk("b_data", b_wdata, eb.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_issue_valid = 0; a_issue_is_load = 0; a_issue_funct3 = 0; a_issue_off = 0;
    a_issue_rd = 0; a_dmem_resp = 0; a_dmem_rdata = 0; a_wb_advance = 0;
  endtask

  task automatic b_idle();
    b_issue_valid = 0; b_issue_is_load = 0; b_issue_funct3 = 0; b_issue_off = 0;
    b_issue_rd = 0; b_dmem_resp = 0; b_dmem_rdata = 0; b_wb_advance = 0;
  endtask

  // Drive one issue on A and queue its hand-computed retirement.
  task automatic a_issue(input logic ld, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] rd, input logic we, input logic [31:0] data);
    a_issue_valid = 1; a_issue_is_load = ld; a_issue_funct3 = f3;
    a_issue_off = off; a_issue_rd = rd;
    qa.push_back('{rd: rd, we: we, data: 64'(data)});
  endtask

  task automatic b_issue(input logic [2:0] f3, input logic [2:0] off,
                         input logic [4:0] rd, input logic [63:0] data);
    b_issue_valid = 1; b_issue_is_load = 1; b_issue_funct3 = f3;
    b_issue_off = off; b_issue_rd = rd;
    qb.push_back('{rd: rd, we: 1'b1, data: data});
  endtask

  // Respond to A while retiring, one response per cycle.
  task automatic a_resp_retire(input logic [31:0] d);
    a_issue_valid = 0; a_dmem_resp = 1; a_dmem_rdata = d; a_wb_advance = 1;
    tick();
  endtask

  initial begin
    a_idle(); b_idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;

    // Reset state
    chk("rst_head_valid", 64'(a_head_valid), 64'd0);
    chk("rst_head_done", 64'(a_head_done), 64'd0);
    chk("rst_regf_we", 64'(a_regf_we), 64'd0);
    chk("rst_rd_addr", 64'(a_rd_addr), 64'd0);
    chk("rst_wdata", 64'(a_wdata), 64'd0);
    chk("rst_issue_ready", 64'(a_issue_ready), 64'd1);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_resp_err", 64'(a_resp_err), 64'd0);

    // Single lb off=2 rd=5, retired through the bypass in the response cycle
    a_issue(1, 3'd0, 2'd2, 5'd5, 1'b1, 32'hFFFF_FFFF);
    tick();
    chk("lb_count_after_push", 64'(a_count), 64'd1);
    a_resp_retire(32'h80FF_1234);
    a_idle();
    chk("lb_count_after_retire", 64'(a_count), 64'd0);

    // Stall capture: four lw held with wb_advance=0
    for (int i = 1; i <= 4; i++) begin
      a_issue(1, 3'd2, 2'd0, 5'(i), 1'b1, 32'h11 * i);
      tick();
    end
    a_issue_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      a_dmem_resp = 1; a_dmem_rdata = 32'h11 * i;
      tick();
    end
    a_idle();
    #1;
    chk("full_count", 64'(a_count), 64'd4);
    chk("full_issue_ready", 64'(a_issue_ready), 64'd0);
    chk("full_head_done", 64'(a_head_done), 64'd1);

    // Push+retire at full: retire buffered 0x11..0x44 while issuing rd 10..13
    for (int j = 0; j < 4; j++) begin
      a_issue(1, 3'd2, 2'd0, 5'(10 + j), 1'b1, 32'hA000_0000 + j);
      a_wb_advance = 1;
      #1;
      chk("pair_ready", 64'(a_issue_ready), 64'd1);
      tick();
      chk("pair_count", 64'(a_count), 64'd4);
    end
    // Two more pairs where the head completes through the bypass
    for (int j = 0; j < 2; j++) begin
      a_issue(1, 3'd2, 2'd0, 5'(14 + j), 1'b1, 32'hA000_0004 + j);
      a_dmem_resp = 1; a_dmem_rdata = 32'hA000_0000 + j; a_wb_advance = 1;
      #1;
      chk("bypass_pair_ready", 64'(a_issue_ready), 64'd1);
      tick();
      chk("bypass_pair_count", 64'(a_count), 64'd4);
    end
    for (int j = 2; j < 6; j++) a_resp_retire(32'hA000_0000 + j);
    a_idle();
    chk("drain_count", 64'(a_count), 64'd0);

    // Store / lhu / lh / lbu mix
    a_issue(0, 3'd2, 2'd0, 5'd3, 1'b0, 32'h0);          tick();
    a_issue(1, 3'd5, 2'd2, 5'd7, 1'b1, 32'h0000_BEEF);  tick();
    a_issue(1, 3'd1, 2'd3, 5'd8, 1'b1, 32'hFFFF_8001);  tick();
    a_issue(1, 3'd4, 2'd1, 5'd9, 1'b1, 32'h0000_0080);  tick();
    a_resp_retire(32'h0000_0000);
    a_resp_retire(32'hBEEF_0000);
    a_resp_retire(32'h8001_0000);
    a_resp_retire(32'h0000_8000);
    // ld (illegal on RV32) gives 0 with write enable kept; lw to x0 has no write enable
    a_idle();
    a_issue(1, 3'd3, 2'd0, 5'd6, 1'b1, 32'h0);          tick();
    a_issue(1, 3'd2, 2'd0, 5'd0, 1'b0, 32'h0000_0055);  tick();
    a_resp_retire(32'hDEAD_BEEF);
    a_resp_retire(32'h0000_0055);
    a_idle();
    chk("mix_count", 64'(a_count), 64'd0);

    // Spurious response on an empty buffer
    a_dmem_resp = 1; a_dmem_rdata = 32'h1234;
    tick();
    a_idle();
    chk("spurious_resp_err", 64'(a_resp_err), 64'd1);
    chk("spurious_count", 64'(a_count), 64'd0);
    tick();
    chk("resp_err_sticky", 64'(a_resp_err), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("resp_err_cleared", 64'(a_resp_err), 64'd0);

    // RV64: lwu off=4, ld full, lw sign-extension
    b_issue(3'd6, 3'd4, 5'd12, 64'h0000_0000_F000_0001); tick();
    b_issue_valid = 0; b_dmem_resp = 1; b_dmem_rdata = 64'hF000_0001_0000_0000; b_wb_advance = 1;
    tick();
    b_idle();
    b_issue(3'd3, 3'd0, 5'd13, 64'h1234_5678_9ABC_DEF0); tick();
    b_issue_valid = 0; b_dmem_resp = 1; b_dmem_rdata = 64'h1234_5678_9ABC_DEF0; b_wb_advance = 1;
    tick();
    b_idle();
    b_issue(3'd2, 3'd0, 5'd14, 64'hFFFF_FFFF_8000_0000); tick();
    b_issue_valid = 0; b_dmem_resp = 1; b_dmem_rdata = 64'h0000_0000_8000_0000; b_wb_advance = 1;
    tick();
    b_idle();
    chk("b_count", 64'(b_count), 64'd0);
    chk("b_resp_err", 64'(b_resp_err), 64'd0);

    tick();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_lsq_retire.md
# wb_lsq_retire

Parametrised writeback retire buffer for memory operations. It tracks up to DEPTH in-order outstanding loads and stores between the memory stage and writeback, and captures data-memory responses that arrive while writeback is stalled. It retires entries in order, and aligns and sign/zero-extends load data to XLEN. This lets the memory stage issue back-to-back accesses without waiting for each response.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 4, maximum outstanding memory operations; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- issue_valid  in  1  memory stage issues a load or store this cycle.
- issue_is_load  in  1  1 = load, 0 = store.
- issue_funct3  in  3  load type (lb/lbu/lh/lhu/lw, plus lwu/ld when XLEN=64).
- issue_off  in  $clog2(XLEN/8)  low byte-address bits of the access.
- issue_rd  in  5  destination register.
- issue_ready  out  1  buffer can accept an issue (not full, or a retire happens this cycle).
- dmem_resp  in  1  data-memory response strobe; responses return in issue order.
- dmem_rdata  in  XLEN  response data.
- wb_advance  in  1  writeback pipeline register enable; retires the head when head_done.
- head_valid  out  1  buffer is non-empty.
- head_done  out  1  head has its response, including a same-cycle response.
- o_regf_we  out  1  head_done & head is a load & rd != 0.
- o_rd_addr  out  5  head destination.
- o_write_data  out  XLEN  aligned, extended head load data.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- resp_err  out  1  sticky flag: a response arrived with no entry awaiting one.

## Operation
- Circular buffer of DEPTH entries. Each entry holds: is_load, funct3, off, rd, done, data.
- Three pointers: head (oldest entry), tail (next free slot), rptr (oldest entry still awaiting a response). Each is $clog2(DEPTH) bits and wraps modulo DEPTH.
- Push: issue_valid & issue_ready writes the entry at tail with done=0 and advances tail. issue_valid while not ready is dropped; the issuer must hold the request.
- Response: when dmem_resp is high and some entry awaits a response (rptr != tail, or an entry is pending), the entry at rptr gets done=1 and data=dmem_rdata, and rptr advances.
  - A response with no awaiting entry is discarded and sets resp_err.
  - An entry pushed in the same cycle cannot receive that cycle's response.
- Bypass: when the response targets the head this cycle, head_done=1 and the output data comes from dmem_rdata directly.
- Retire: wb_advance & head_done pops the head.
- Push and retire in the same cycle at count=DEPTH is legal; count is unchanged.
- Stores retire with o_regf_we=0 and o_write_data=0.
- Alignment for XLEN=32:
  - lb/lbu: byte at off, sign- or zero-extended.
  - lh/lhu: halfword at off[1] (off[0] is ignored), sign- or zero-extended.
  - lw: full word.
- Alignment for XLEN=64 adds lwu/lw (word at off[2]) and ld (full).
- Illegal funct3 for the configured XLEN produces data 0 with o_regf_we unchanged.
- resp_err clears only on rst.

## Timing
- Reset values: head=tail=rptr=0, count=0, all done bits=0, resp_err=0.
  - Therefore head_valid=0, head_done=0, o_regf_we=0, o_rd_addr=0, o_write_data=0, issue_ready=1.
- Push: count and head_valid update on the next clock edge.
- Response-to-retire latency: 0 cycles through the bypass. A response held in the buffer retires on the first cycle with wb_advance=1.
- Output ports are combinational from head state plus the bypass path; there is no internal output register.
- issue_ready = (count < DEPTH) | (wb_advance & head_done). This is combinational through wb_advance.
- Reset mid-operation discards all entries. Responses after reset for pre-reset issues are spurious and set resp_err.

## Structure
- Shared package (rv32imc_types):
  - existing funct3 load enum, extended with lwu/ld;
  - new typedef wb_lsq_entry_t {is_load, funct3, off, rd, done, data}.
- Sub-module wb_load_align: combinational data/funct3/off to aligned XLEN result, parametrised on XLEN. It is reused by the bypass and buffered paths.

## Test plan
- Single lb: issue off=2, rd=5. The response 0x80FF_1234 arrives a cycle later with wb_advance=1. Required: o_write_data=0xFFFF_FFFF, o_regf_we=1, retired in the response cycle.
- Stall capture, DEPTH=4: issue 4 loads lw rd=1..4 and hold wb_advance=0. Responses 0x11, 0x22, 0x33, 0x44 arrive. Required: count=4, issue_ready=0. Then wb_advance=1 for 4 cycles retires 0x11..0x44 in order.
- Full with simultaneous push and retire: with count=4 and head_done, assert issue_valid and wb_advance together. Required: issue_ready=1 and count stays 4; pointers wrap correctly after 6 further issue/retire pairs.
- Store and lhu mix: issue a store, then lhu off=2 rd=7, with responses 0x0 and 0xBEEF_0000. Required: store retires with o_regf_we=0; lhu retires 0x0000_BEEF.
- Spurious response: pulse dmem_resp with the buffer empty. Required: resp_err=1, count=0. Apply rst. Required: resp_err=0.
- XLEN=64 ld/lwu: lwu off=4 with response 0xF000_0001_0000_0000 gives 0x0000_0000_F000_0001. ld returns the full 64 bits.
